// File: rtl/caf_lock_detect_pkg.sv
// Shared definitions for the CAF lock detector: state codes, status-word
// layout and the count saturation value.
package caf_lock_detect_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int LOCK_BIT  = 31;
    localparam int STATE_MSB = 30;
    localparam int STATE_LSB = 29;
    localparam int COUNT_MSB = 28;
    localparam int COUNT_LSB = 24;
    localparam int COUNT_W   = COUNT_MSB - COUNT_LSB + 1;
    localparam int MISS_W    = 4;
    localparam int CAND_W    = COUNT_LSB;

    localparam logic [COUNT_W-1:0] COUNT_SAT = 5'd31;

    // Status word: lock flag, state, count, then the zero-extended candidate.
    function automatic logic [31:0] pack_status(
        input state_t             st,
        input logic [COUNT_W-1:0] cnt,
        input logic [CAND_W-1:0]  cand
    );
        logic [31:0] w;
        w                      = '0;
        w[LOCK_BIT]            = (st == ST_LOCKED);
        w[STATE_MSB:STATE_LSB] = st;
        w[COUNT_MSB:COUNT_LSB] = cnt;
        w[CAND_W-1:0]          = cand;
        return w;
    endfunction

endpackage

// File: rtl/caf_tol_compare.sv
// Unsigned absolute-difference compare: within_tol when |a - b| <= TOL.
// No wrap-around, so the extremes of the range are maximally far apart.
module caf_tol_compare #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TOL   = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             within_tol
);

    logic [WIDTH-1:0] diff;

    always_comb begin
        diff       = (a >= b) ? (a - b) : (b - a);
        within_tol = (32'(diff) <= TOL);
    end

endmodule

// File: rtl/caf_lock_detect.sv
// Tracks CAF peak results across runs, declares/drops lock, and emits one
// status word per consumed result through a single-register output stage.
module caf_lock_detect
    import caf_lock_detect_pkg::*;
#(
    parameter int unsigned INDEX_BITS   = 8,
    parameter int unsigned FREQ_BITS    = 3,
    parameter int unsigned INDEX_TOL    = 1,
    parameter int unsigned FREQ_TOL     = 0,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] m_axis_tdata,
    input  logic        m_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] s_axis_tdata,
    output logic        s_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        locked,
    output logic        lock_lost
);

    localparam int unsigned RES_W = INDEX_BITS + FREQ_BITS;
    localparam logic [COUNT_W-1:0] LOCK_CNT   = COUNT_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  UNLOCK_CNT = MISS_W'(UNLOCK_COUNT);

    state_t                state;
    logic [COUNT_W-1:0]    count;
    logic [MISS_W-1:0]     miss;
    logic [INDEX_BITS-1:0] cand_idx;
    logic [FREQ_BITS-1:0]  cand_frq;

    state_t                state_nxt;
    logic [COUNT_W-1:0]    count_nxt;
    logic [MISS_W-1:0]     miss_nxt;
    logic [INDEX_BITS-1:0] cand_idx_nxt;
    logic [FREQ_BITS-1:0]  cand_frq_nxt;
    logic                  lost_nxt;
    state_t                eval_state;

    logic [INDEX_BITS-1:0] res_idx;
    logic [FREQ_BITS-1:0]  res_frq;
    logic                  idx_ok;
    logic                  frq_ok;
    logic                  agree;
    logic                  accept;
    logic                  unused_tdata;

    assign res_frq      = m_axis_tdata[FREQ_BITS-1:0];
    assign res_idx      = m_axis_tdata[RES_W-1:FREQ_BITS];
    assign unused_tdata = ^m_axis_tdata[31:RES_W];

    assign s_axis_tready = !s_axis_tvalid || m_axis_tready;
    assign accept        = m_axis_tvalid && s_axis_tready;

    caf_tol_compare #(
        .WIDTH (INDEX_BITS),
        .TOL   (INDEX_TOL)
    ) u_idx_cmp (
        .a          (res_idx),
        .b          (cand_idx),
        .within_tol (idx_ok)
    );

    caf_tol_compare #(
        .WIDTH (FREQ_BITS),
        .TOL   (FREQ_TOL)
    ) u_frq_cmp (
        .a          (res_frq),
        .b          (cand_frq),
        .within_tol (frq_ok)
    );

    assign agree = idx_ok && frq_ok;

    // Post-update tracking state for the result on the input, assuming it is
    // accepted; a simultaneous clear makes it start afresh as in SEARCH.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_nxt    = state;
        count_nxt    = count;
        miss_nxt     = miss;
        cand_idx_nxt = cand_idx;
        cand_frq_nxt = cand_frq;
        lost_nxt     = 1'b0;
        eval_state   = clear ? ST_SEARCH : state;

        case (eval_state)
            ST_VERIFY: begin
                if (agree) begin
                    count_nxt = count + 1'b1;
                    if (count_nxt == LOCK_CNT) begin
                        state_nxt = ST_LOCKED;
                    end
                end else begin
                    cand_idx_nxt = res_idx;
                    cand_frq_nxt = res_frq;
                    count_nxt    = COUNT_W'(1);
                end
            end

            ST_LOCKED: begin
                if (agree) begin
                    cand_idx_nxt = res_idx;
                    cand_frq_nxt = res_frq;
                    count_nxt    = (count == COUNT_SAT) ? COUNT_SAT : count + 1'b1;
                    miss_nxt     = '0;
                end else begin
                    miss_nxt = miss + 1'b1;
                    if (miss_nxt == UNLOCK_CNT) begin
                        state_nxt = ST_SEARCH;
                        count_nxt = '0;
                        miss_nxt  = '0;
                        lost_nxt  = 1'b1;
                    end
                end
            end

            // SEARCH, and the unused encoding, restart tracking on this result.
            default: begin
                cand_idx_nxt = res_idx;
                cand_frq_nxt = res_frq;
                count_nxt    = COUNT_W'(1);
                miss_nxt     = '0;
                state_nxt    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_SEARCH;
            count         <= '0;
            miss          <= '0;
            cand_idx      <= '0;
            cand_frq      <= '0;
            locked        <= 1'b0;
            lock_lost     <= 1'b0;
            s_axis_tvalid <= 1'b0;
            s_axis_tdata  <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (accept) begin
                state         <= state_nxt;
                count         <= count_nxt;
                miss          <= miss_nxt;
                cand_idx      <= cand_idx_nxt;
                cand_frq      <= cand_frq_nxt;
                locked        <= (state_nxt == ST_LOCKED);
                lock_lost     <= lost_nxt;
                s_axis_tvalid <= 1'b1;
                s_axis_tdata  <= pack_status(state_nxt, count_nxt,
                                             CAND_W'({cand_idx_nxt, cand_frq_nxt}));
            end else begin
                // A bare clear resets tracking but leaves the output stage alone.
                if (clear) begin
                    state  <= ST_SEARCH;
                    count  <= '0;
                    miss   <= '0;
                    locked <= 1'b0;
                end
                if (m_axis_tready) begin
                    s_axis_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_caf_lock_detect.sv
// Scoreboard bench for caf_lock_detect: driver steps a behavioural model on
// every accepted result, a negedge monitor pops and compares every status word.
module tb_caf_lock_detect;

    localparam int INDEX_BITS   = 8;
    localparam int FREQ_BITS    = 3;
    localparam int INDEX_TOL    = 1;
    localparam int FREQ_TOL     = 0;
    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 2;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic        locked;
    logic        lock_lost;

    caf_lock_detect #(
        .INDEX_BITS   (INDEX_BITS),
        .FREQ_BITS    (FREQ_BITS),
        .INDEX_TOL    (INDEX_TOL),
        .FREQ_TOL     (FREQ_TOL),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .locked        (locked),
        .lock_lost     (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: 0 = searching, 1 = verifying, 2 = locked.
    int m_state = 0;
    int m_cnt   = 0;
    int m_miss  = 0;
    int m_cidx  = 0;
    int m_cfrq  = 0;

    logic [31:0] sb[$];
    logic [31:0] pend_word  = '0;
    bit          pend_valid = 0;
    bit          pend_lost  = 0;
    logic        exp_locked;
    logic        exp_lost;
    logic [31:0] last_word  = '0;
    int          rdy_mode   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_miss = 0; m_cidx = 0; m_cfrq = 0;
    endtask

    task automatic model_clear();
        m_state = 0; m_cnt = 0; m_miss = 0;
    endtask

    task automatic model_accept(input int idx, input int frq, input bit clr);
        bit agree;
        bit lost;
        lost  = 0;
        agree = (absdiff(idx, m_cidx) <= INDEX_TOL) && (absdiff(frq, m_cfrq) <= FREQ_TOL);
        if (clr || m_state == 0) begin
            m_cidx = idx; m_cfrq = frq; m_cnt = 1; m_miss = 0;
            m_state = (LOCK_COUNT == 1) ? 2 : 1;
        end else if (m_state == 1) begin
            if (agree) begin
                m_cnt++;
                if (m_cnt == LOCK_COUNT) m_state = 2;
            end else begin
                m_cidx = idx; m_cfrq = frq; m_cnt = 1;
            end
        end else begin
            if (agree) begin
                m_cidx = idx; m_cfrq = frq; m_miss = 0;
                if (m_cnt < 31) m_cnt++;
            end else begin
                m_miss++;
                if (m_miss == UNLOCK_COUNT) begin
                    m_state = 0; m_cnt = 0; m_miss = 0; lost = 1;
                end
            end
        end
        pend_word  = ((m_state == 2) ? 32'h8000_0000 : 32'h0) | (32'(m_state) << 29)
                   | (32'(m_cnt) << 24) | (32'(m_cidx) << FREQ_BITS) | 32'(m_cfrq);
        pend_valid = 1;
        pend_lost  = lost;
    endtask

    // Captured words enter the scoreboard on the edge the DUT registers them.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_locked <= 1'b0;
            exp_lost   <= 1'b0;
        end else begin
            exp_locked <= (m_state == 2);
            exp_lost   <= pend_lost;
            if (pend_valid) sb.push_back(pend_word);
            pend_valid = 0;
            pend_lost  = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 9) < 7);
            default: m_axis_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("tready", {31'b0, s_axis_tready}, {31'b0, !s_axis_tvalid || m_axis_tready});
            check("tvalid", {31'b0, s_axis_tvalid}, {31'b0, sb.size() != 0});
            check("locked", {31'b0, locked}, {31'b0, exp_locked});
            check("lock_lost", {31'b0, lock_lost}, {31'b0, exp_lost});
            if (s_axis_tvalid && sb.size() != 0) begin
                check("tdata", s_axis_tdata, sb[0]);
                if (m_axis_tready) begin
                    last_word = s_axis_tdata;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input int idx, input int frq, input bit clr);
        logic [31:0] w;
        int budget;
        bit done;
        budget = 0;
        done   = 0;
        @(posedge clk);
        #1;
        w = $urandom();
        w[FREQ_BITS-1:0] = FREQ_BITS'(frq);
        w[INDEX_BITS+FREQ_BITS-1:FREQ_BITS] = INDEX_BITS'(idx);
        m_axis_tdata  = w;
        m_axis_tvalid = 1'b1;
        clear         = clr;
        while (!done) begin
            #1;
            if (s_axis_tready) begin
                model_accept(idx, frq, clr);
                done = 1;
            end else begin
                if (clr) model_clear();
                budget++;
                if (budget > 200) begin
                    check("accept_timeout", 32'(budget), 32'd0);
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            m_axis_tvalid = 1'b0;
            clear         = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        m_axis_tvalid = 1'b0;
        clear         = 1'b1;
        #1;
        model_clear();
    endtask

    task automatic acquire();
        repeat (LOCK_COUNT) send(10, 2, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_idx;
        int base_frq;
        int idx;
        int frq;
        int r;
        int budget;

        rst           = 1'b1;
        clear         = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tvalid", {31'b0, s_axis_tvalid}, 32'd0);
        check("rst_tdata", s_axis_tdata, 32'd0);
        check("rst_locked", {31'b0, locked}, 32'd0);
        check("rst_lock_lost", {31'b0, lock_lost}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Lock acquisition, then lock loss on two frequency misses.
        acquire();
        idle(2);
        check("acquire_word", last_word, 32'hC400_0052);
        check("acquire_locked", {31'b0, locked}, 32'd1);
        send(10, 3, 0);
        send(10, 3, 0);
        idle(3);

        // Tolerance edge: 11 and 9 agree with 10, 12 does not.
        do_clear();
        send(10, 2, 0);
        send(11, 2, 0);
        send(9, 2, 0);
        send(12, 2, 0);
        idle(2);
        check("tol_edge_word", last_word, 32'h2100_0062);

        // No wrap-around: 0 and 255 are far apart, 254/255 agree.
        do_clear();
        send(0, 0, 0);
        send(0, 0, 0);
        send(255, 0, 0);
        send(254, 0, 0);
        idle(2);

        // Backpressure: a word held five cycles while the next result waits.
        do_clear();
        rdy_mode = 2;
        send(40, 1, 0);
        fork
            send(41, 1, 0);
            begin
                repeat (6) @(posedge clk);
                rdy_mode = 0;
            end
        join
        send(40, 1, 0);
        idle(3);

        // clear together with an accept while locked.
        do_clear();
        acquire();
        send(20, 5, 1);
        idle(2);
        check("clear_accept_word", last_word, 32'h2100_00A5);
        check("clear_accept_locked", {31'b0, locked}, 32'd0);

        // Asynchronous reset between edges while locked with a word pending.
        do_clear();
        acquire();
        idle(2);
        rdy_mode = 2;
        send(10, 2, 0);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", {31'b0, s_axis_tvalid}, 32'd0);
        check("async_rst_tdata", s_axis_tdata, 32'd0);
        check("async_rst_locked", {31'b0, locked}, 32'd0);
        model_reset();
        sb.delete();
        pend_valid    = 0;
        pend_lost     = 0;
        m_axis_tvalid = 1'b0;
        clear         = 1'b0;
        rdy_mode      = 0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        send(10, 2, 0);
        idle(2);
        check("post_rst_word", last_word, 32'h2100_0052);

        // Randomised traffic clustered around a slowly moving candidate.
        base_idx = 100;
        base_frq = 3;
        for (int t = 0; t < 500; t++) begin
            if ($urandom_range(0, 24) == 0) begin
                base_idx = int'($urandom_range(0, 255));
                base_frq = int'($urandom_range(0, 7));
            end
            if (t % 100 == 0) rdy_mode = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_clear();
            end else if (r < 10) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                idx = base_idx + int'($urandom_range(0, 4)) - 2;
                if (idx < 0) idx = 0;
                if (idx > 255) idx = 255;
                frq = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : base_frq;
                send(idx, frq, $urandom_range(0, 49) == 0);
            end
        end

        rdy_mode = 0;
        idle(2);
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
